// File: rtl/mario_objdma.sv
// Sprite DMA initiator: takes the Z80 bus, copies LENGTH bytes starting at
// SRC_BASE out of CPU work RAM and presents them on the object-RAM write port.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | bus released; a start edge sets pending, next cen leaves
// REQ     | BUSRQn asserted, waiting for BUSAKn low on a cen
// READ    | source address and RDn driven; data latched on the next cen
// WRITE   | one-clock CE already issued; advance counter or finish
// RELEASE | BUSRQn released, waiting for the CPU to drop its acknowledge
module mario_objdma #(
  parameter logic [15:0] SRC_BASE = 16'h6900,
  parameter int          LENGTH   = 384
) (
  input  logic        I_CLK_48M,
  input  logic        I_RESETn,
  input  logic        I_CEN_6M,
  input  logic        I_START,
  input  logic        I_BUSAKn,
  input  logic [7:0]  I_SRC_D,
  output logic        O_BUSRQn,
  output logic [15:0] O_SRC_A,
  output logic        O_SRC_RDn,
  output logic [9:0]  O_OBJDMA_A,
  output logic [7:0]  O_OBJDMA_D,
  output logic        O_OBJDMA_CE,
  output logic        O_BUSY
);

  // A counter of 10 bits covers every legal length; anything else is refused.
  if (LENGTH < 1 || LENGTH > 1024) begin : g_bad_length
    $error("mario_objdma: LENGTH must lie in 1..1024");
  end

  localparam logic [9:0] LAST = 10'(LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WRITE,
    S_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        start_q;
  logic [9:0]  obj_a_q, obj_a_d;
  logic [7:0]  obj_d_q, obj_d_d;
  logic        ce_q, ce_d;

  // State, counter, edge history and write-port registers.
  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
      obj_a_q <= '0;
      obj_d_q <= '0;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      start_q <= I_START;
      obj_a_q <= obj_a_d;
      obj_d_q <= obj_d_d;
      ce_q    <= ce_d;
    end
  end

  // Next-state logic; a high BUSAKn during READ/WRITE simply holds everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    obj_a_d = obj_a_q;
    obj_d_d = obj_d_q;
    ce_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_START && !start_q) pend_d = 1'b1;
        if (I_CEN_6M && pend_q) begin
          pend_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (I_CEN_6M && !I_BUSAKn) begin
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (I_CEN_6M && !I_BUSAKn) begin
          obj_d_d = I_SRC_D;
          obj_a_d = cnt_q;
          ce_d    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (I_CEN_6M && !I_BUSAKn) begin
          if (cnt_q == LAST) begin
            state_d = S_RELEASE;
          end else begin
            cnt_d   = cnt_q + 10'd1;
            state_d = S_READ;
          end
        end
      end
      S_RELEASE: begin
        if (I_CEN_6M && I_BUSAKn) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus-side outputs decode straight from state so reset releases them at once.
  always_comb begin
    O_BUSRQn    = !(state_q == S_REQ || state_q == S_READ || state_q == S_WRITE);
    O_SRC_RDn   = (state_q != S_READ);
    O_SRC_A     = SRC_BASE + {6'd0, cnt_q};
    O_BUSY      = (state_q != S_IDLE) || pend_q;
    O_OBJDMA_A  = obj_a_q;
    O_OBJDMA_D  = obj_d_q;
    O_OBJDMA_CE = ce_q;
  end

endmodule
